// File: rtl/cache_ctrl_pkg.sv
// Shared types and address helpers for the L1 cache controller and its
// block-based memory port.
package cache_ctrl_pkg;

   localparam int ADDR_WIDTH   = 16;
   localparam int WORD_WIDTH   = 16;
   localparam int BLOCK_SIZE   = 4;
   localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
   localparam int CACHE_SETS   = 16;

   typedef logic [WORD_WIDTH-1:0]                 word_t;
   typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

   typedef struct packed {
      logic                  valid;
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      word_t                 data;
   } cpu_request_t;

   typedef struct packed {
      logic  ready;
      word_t data;
   } cpu_response_t;

   typedef struct packed {
      logic                  cs;
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      block_t                data;
   } memory_request_t;

   typedef struct packed {
      logic   ack;
      block_t data;
   } memory_response_t;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} cache_state_t;

   function automatic logic [OFFSET_WIDTH-1:0] get_offset(input logic [ADDR_WIDTH-1:0] addr);
      return addr[OFFSET_WIDTH-1:0];
   endfunction

   // Index/tag results are full address width; callers truncate to their field size.
   function automatic logic [ADDR_WIDTH-1:0] get_index(input logic [ADDR_WIDTH-1:0] addr,
                                                      input int index_width);
      return (addr >> OFFSET_WIDTH) & ((ADDR_WIDTH'(1) << index_width) - ADDR_WIDTH'(1));
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] get_tag(input logic [ADDR_WIDTH-1:0] addr,
                                                    input int index_width);
      return addr >> (OFFSET_WIDTH + index_width);
   endfunction

endpackage

// File: rtl/cache_store.sv
// Tag/data store for the direct-mapped cache: combinational read of one set,
// block fill from memory and single-word CPU write into the same set.
module cache_store import cache_ctrl_pkg::*; #(
   parameter int NUM_SETS  = CACHE_SETS,
   parameter int TAG_WIDTH = ADDR_WIDTH - $clog2(CACHE_SETS) - OFFSET_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [$clog2(NUM_SETS)-1:0] idx,
   output logic                        valid,
   output logic                        dirty,
   output logic [TAG_WIDTH-1:0]        tag,
   output block_t                      data,
   input  logic                        fill_en,
   input  logic [TAG_WIDTH-1:0]        fill_tag,
   input  block_t                      fill_data,
   input  logic                        word_en,
   input  logic [OFFSET_WIDTH-1:0]     word_off,
   input  word_t                       word_data
);

   logic [NUM_SETS-1:0]  valid_q;
   logic [NUM_SETS-1:0]  dirty_q;
   logic [TAG_WIDTH-1:0] tag_q  [NUM_SETS];
   block_t               data_q [NUM_SETS];

   assign valid = valid_q[idx];
   assign dirty = dirty_q[idx];
   assign tag   = tag_q[idx];
   assign data  = data_q[idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_en) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data payload carry no reset; valid gates every use of them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[idx]  <= fill_tag;
         data_q[idx] <= fill_data;
      end else if (word_en) begin
         data_q[idx][word_off] <= word_data;
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 cache controller between a
// single-word CPU port and a block-based memory controller.
module cache_ctrl import cache_ctrl_pkg::*; #(
   parameter int NUM_SETS = CACHE_SETS
) (
   input  logic             clk,
   input  logic             rst,
   input  cpu_request_t     cpu_req,
   output cpu_response_t    cpu_res,
   output memory_request_t  mem_req,
   input  memory_response_t mem_res
);

   localparam int INDEX_WIDTH = $clog2(NUM_SETS);
   localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

   cache_state_t          state, state_nxt;
   logic                  req_rw;
   logic [ADDR_WIDTH-1:0] req_addr;
   word_t                 req_data;
   logic                  ack_q;

   logic [INDEX_WIDTH-1:0]  idx;
   logic [TAG_WIDTH-1:0]    req_tag;
   logic [OFFSET_WIDTH-1:0] off;
   logic                    line_valid, line_dirty;
   logic [TAG_WIDTH-1:0]    line_tag;
   block_t                  line_data;
   logic                    hit, mem_active, mem_done, fill_en, word_en;

   assign idx     = INDEX_WIDTH'(get_index(req_addr, INDEX_WIDTH));
   assign req_tag = TAG_WIDTH'(get_tag(req_addr, INDEX_WIDTH));
   assign off     = get_offset(req_addr);

   assign hit = line_valid && (line_tag == req_tag);

   // ack_q blanks cs for the cycle after an ack, so a write-back followed
   // directly by a refill still shows the memory side a cs gap.
   assign mem_active = ((state == WRITE_BACK) || (state == ALLOCATE)) && !ack_q;
   assign mem_done   = mem_active && mem_res.ack;
   assign fill_en    = (state == ALLOCATE) && mem_done;
   assign word_en    = (state == COMPARE) && hit && req_rw;

   cache_store #(.NUM_SETS(NUM_SETS), .TAG_WIDTH(TAG_WIDTH)) u_store (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .valid     (line_valid),
      .dirty     (line_dirty),
      .tag       (line_tag),
      .data      (line_data),
      .fill_en   (fill_en),
      .fill_tag  (req_tag),
      .fill_data (mem_res.data),
      .word_en   (word_en),
      .word_off  (off),
      .word_data (req_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req_rw   <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         ack_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         ack_q <= mem_done;
         if (state == IDLE && cpu_req.valid) begin
            req_rw   <= cpu_req.rw;
            req_addr <= cpu_req.addr;
            req_data <= cpu_req.data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cpu_res   = '0;
      mem_req   = '0;
      case (state)
         IDLE: if (cpu_req.valid) state_nxt = COMPARE;
         COMPARE: begin
            if (hit) begin
               cpu_res.ready = 1'b1;
               if (!req_rw) cpu_res.data = line_data[off];
               state_nxt = IDLE;
            end else if (line_valid && line_dirty) begin
               state_nxt = WRITE_BACK;
            end else begin
               state_nxt = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            if (mem_active) begin
               mem_req.cs   = 1'b1;
               mem_req.rw   = 1'b1;
               mem_req.addr = {line_tag, idx, {OFFSET_WIDTH{1'b0}}};
               mem_req.data = line_data;
            end
            if (mem_done) state_nxt = ALLOCATE;
         end
         ALLOCATE: begin
            if (mem_active) begin
               mem_req.cs   = 1'b1;
               mem_req.addr = {req_tag, idx, {OFFSET_WIDTH{1'b0}}};
            end
            if (mem_done) state_nxt = COMPARE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl: a behavioural memory responder plus a
// reference model of architectural memory contents and per-set line state.
module tb_cache_ctrl;
   import cache_ctrl_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   cpu_request_t     cpu_req;
   cpu_response_t    cpu_res;
   memory_request_t  mem_req;
   memory_response_t mem_res;

   cache_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .cpu_req (cpu_req),
      .cpu_res (cpu_res),
      .mem_req (mem_req),
      .mem_res (mem_res)
   );

   always #5 clk = ~clk;

   word_t ram  [1024];   // memory behind the memory port
   word_t arch [1024];   // value the CPU must observe at each address
   bit    m_valid [16];
   bit    m_dirty [16];
   int    m_tag   [16];

   memory_request_t txn_q[$];
   int  vectors = 0;
   int  errors  = 0;
   bit  hold_ack = 1'b0;
   bit  real_ack = 1'b0;
   int  wait_cnt = -1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory responder: random latency, one-cycle ack, occasional stray acks while idle.
   initial begin
      mem_res = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_res.ack = 1'b0;
            wait_cnt    = -1;
            real_ack    = 1'b0;
         end else if (mem_res.ack) begin
            mem_res.ack = 1'b0;
            if (real_ack) chk("cs_drop", mem_req.cs, 0);
            real_ack = 1'b0;
         end else if (mem_req.cs && !hold_ack) begin
            if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
            if (wait_cnt == 0) begin
               int a;
               a = int'(mem_req.addr);
               txn_q.push_back(mem_req);
               for (int i = 0; i < BLOCK_SIZE; i++) begin
                  if (mem_req.rw) ram[a+i] = mem_req.data[i];
                  else            mem_res.data[i] = ram[a+i];
               end
               mem_res.ack = 1'b1;
               real_ack    = 1'b1;
               wait_cnt    = -1;
            end else begin
               wait_cnt--;
            end
         end else if (!mem_req.cs && !hold_ack && $urandom_range(0, 7) == 0) begin
            mem_res.data = {$urandom, $urandom};
            mem_res.ack  = 1'b1;
            real_ack     = 1'b0;
         end
      end
   end

   task automatic cpu_op(input bit rw, input int addr, input word_t wdata);
      int set, tg, base, vbase, n;
      bit hit;
      memory_request_t e;
      memory_request_t exp_q[$];
      set  = (addr >> 2) & 15;
      tg   = addr >> 6;
      base = addr & ~3;
      hit  = m_valid[set] && (m_tag[set] == tg);
      if (!hit) begin
         if (m_valid[set] && m_dirty[set]) begin
            vbase  = m_tag[set] * 64 + set * 4;
            e      = '0;
            e.cs   = 1'b1;
            e.rw   = 1'b1;
            e.addr = 16'(vbase);
            for (int i = 0; i < BLOCK_SIZE; i++) e.data[i] = arch[vbase+i];
            exp_q.push_back(e);
         end
         e      = '0;
         e.cs   = 1'b1;
         e.addr = 16'(base);
         exp_q.push_back(e);
         m_valid[set] = 1'b1;
         m_tag[set]   = tg;
         m_dirty[set] = 1'b0;
      end
      if (rw) begin
         arch[addr]   = wdata;
         m_dirty[set] = 1'b1;
      end
      txn_q.delete();

      @(posedge clk); #1;
      cpu_req.valid = 1'b1;
      cpu_req.rw    = rw;
      cpu_req.addr  = 16'(addr);
      cpu_req.data  = wdata;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk("idle_ready", cpu_res.ready, 0);
            chk("idle_data", cpu_res.data, 0);
            chk("idle_cs", mem_req.cs, 0);
         end
      end while (!cpu_res.ready && n < 200);
      chk("ready_seen", cpu_res.ready, 1);
      if (hit) chk("hit_latency", n, 2);
      chk("ready_cs", mem_req.cs, 0);
      if (!rw) chk("rdata", cpu_res.data, arch[addr]);
      @(posedge clk); #1;
      cpu_req.valid = 1'b0;

      chk("txn_count", txn_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++) begin
         chk("txn_rw", txn_q[i].rw, exp_q[i].rw);
         chk("txn_addr", txn_q[i].addr, exp_q[i].addr);
         if (exp_q[i].rw) chk("txn_wdata", txn_q[i].data, exp_q[i].data);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 16; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
         m_tag[s]   = 0;
      end
      // dirty lines are lost on reset; the CPU now sees backing memory
      for (int i = 0; i < 1024; i++) arch[i] = ram[i];
   endtask

   initial begin
      int n;
      cpu_req = '0;
      for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
      ram['h010] = 16'hA0A0;
      ram['h011] = 16'hA1A1;
      ram['h012] = 16'hA2A2;
      ram['h013] = 16'hA3A3;
      model_reset();

      rst = 1'b1;
      #1;
      chk("rst_ready", cpu_res.ready, 0);
      chk("rst_data", cpu_res.data, 0);
      chk("rst_cs", mem_req.cs, 0);
      chk("rst_rw", mem_req.rw, 0);
      chk("rst_addr", mem_req.addr, 0);
      chk("rst_mdata", mem_req.data, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // cold miss, hit, write hit, dirty eviction, write miss
      cpu_op(0, 'h012, 0);
      cpu_op(0, 'h013, 0);
      cpu_op(1, 'h011, 16'hBEEF);
      cpu_op(0, 'h011, 0);
      cpu_op(0, 'h050, 0);
      chk("wb_ram", ram['h011], 16'hBEEF);
      cpu_op(1, 'h0A3, 16'h1234);
      cpu_op(0, 'h0A3, 0);
      cpu_op(0, 'h0A0, 0);
      // lowest and highest set
      cpu_op(0, 'h000, 0);
      cpu_op(0, 'h03C, 0);
      cpu_op(0, 'h03F, 0);
      cpu_op(0, 'h040, 0);
      cpu_op(0, 'h07F, 0);

      // reset while a refill is outstanding
      hold_ack = 1'b1;
      @(posedge clk); #1;
      cpu_req.valid = 1'b1;
      cpu_req.rw    = 1'b0;
      cpu_req.addr  = 16'h0200;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req.cs && n < 50);
      chk("pre_rst_cs", mem_req.cs, 1);
      chk("pre_rst_addr", mem_req.addr, 16'h0200);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_cs", mem_req.cs, 0);
      chk("mid_rst_ready", cpu_res.ready, 0);
      cpu_req.valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      hold_ack = 1'b0;
      model_reset();
      cpu_op(0, 'h0200, 0);
      cpu_op(0, 'h0201, 0);

      for (int k = 0; k < 300; k++) begin
         int a;
         a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 'h7F) : $urandom_range(0, 'h3FF);
         cpu_op($urandom_range(0, 1), a, 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 cache controller.
- Sits between the CPU-side requester and the block-based memory controller.
- Accepts single-word CPU reads and writes, and serves hits from a local tag/data store.
- On a miss, issues whole-block memory_request_t transactions: optional dirty-victim write-back, then a refill. It consumes memory_response_t and completes the CPU request when the refill is done.

Parameters:
- NUM_SETS, default 16: number of cache lines; must be a power of 2. INDEX_WIDTH = $clog2(NUM_SETS).
- TAG_WIDTH, default ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH: stored tag width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  cpu_request_t  fields: valid, rw (1=write), addr[ADDR_WIDTH], data[WORD_WIDTH].
- cpu_res  out  cpu_response_t  fields: ready, data[WORD_WIDTH].
- mem_req  out  memory_request_t  fields: cs, rw, addr, data[BLOCK_SIZE].
- mem_res  in  memory_response_t  fields: ack, data[BLOCK_SIZE].

Behaviour:
- Address split: offset = addr[OFFSET_WIDTH-1:0]; index = next INDEX_WIDTH bits; tag = remaining upper bits.
- Reset (async, any state):
  - state <= IDLE; all valid and dirty bits cleared; latched request cleared.
  - cpu_res.ready=0, cpu_res.data=0, mem_req.cs=0, mem_req.rw=0, mem_req.addr=0, mem_req.data=0.
  - Data/tag arrays are not reset.
  - A memory transaction in flight is abandoned. mem_ctrl is reset by the same rst.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE:
  - cpu_req.valid=1 -> latch addr/rw/data into req_q, go to COMPARE.
  - cpu_req is ignored in every other state.
- COMPARE (combinational lookup on req_q):
  - Hit (valid & tag match): cpu_res.ready=1 this cycle, combinational, single-cycle pulse.
    - Read: cpu_res.data = line word[offset].
    - Write: word[offset] <= req_q.data and dirty <= 1 at the closing edge.
    - Next state IDLE.
  - Miss, line clean or invalid -> ALLOCATE.
  - Miss, line valid & dirty -> WRITE_BACK.
- WRITE_BACK:
  - mem_req.cs=1, rw=1, addr={stored_tag,index,OFFSET_WIDTH'b0}, data=stored block.
  - Held constant until mem_res.ack; on ack -> ALLOCATE.
- ALLOCATE:
  - mem_req.cs=1, rw=0, addr={req_tag,index,0}.
  - On ack: line data <= mem_res.data, tag <= req_tag, valid <= 1, dirty <= 0; next state COMPARE (re-lookup now hits).
- Memory handshake:
  - cs is driven only in WRITE_BACK and ALLOCATE, and is decoded from the registered state.
  - cs stays high through the ack cycle and is low the cycle after; mem_ctrl must not see cs held across ack.
  - mem_res.data is sampled only in the ack cycle. ack is a one-cycle pulse; no latency is assumed.
  - ack outside WRITE_BACK/ALLOCATE is ignored.
- CPU handshake:
  - Requester holds cpu_req until it sees ready. It may present the next request in the cycle after ready.
  - cpu_res.data is don't-care when ready=0; drive 0.
- Latency:
  - Hit: valid seen in IDLE cycle c0, ready in c1.
  - Clean miss: c0 IDLE, ALLOCATE for Lm cycles, COMPARE ready.
  - Dirty miss: additional WRITE_BACK phase of Lm cycles before ALLOCATE.
- Write miss: allocate the block, then merge the CPU word in COMPARE; line ends dirty.
- Index 0 and index NUM_SETS-1 behave identically; the address is never incremented here, so there is no wrap-around.

Decomposition:
- Add to cache_parameters:
  - cpu_request_t and cpu_response_t structs.
  - cache_state_t enum.
  - CACHE_SETS constant, the default for NUM_SETS.
  - Helper functions get_tag, get_index, get_offset.
- Sub-module cache_store holds the arrays:
  - Registered valid/dirty/tag/data arrays.
  - Async-reset valid/dirty.
  - Combinational read port; one write port for full-block fill and one for word write.
- cache_ctrl holds the FSM, req_q, and the mem_req/cpu_res muxing.

Test Plan:
All cases use BLOCK_SIZE=4, NUM_SETS=16, with cache_ctrl connected to mem_ctrl+ram.
- Cold read miss: preload ram[0x010..0x013]=A0..A3. Read 0x012 -> one ALLOCATE with mem addr 0x010, rw=0; ready with data A2. Re-read 0x013 -> hit, ready 1 cycle after valid, data A3, no cs.
- Write hit: write 0x011=0xBEEF after the fill -> ready on hit with no memory traffic. Read 0x011 returns 0xBEEF and the line is dirty.
- Dirty eviction: read 0x050 (index 4, tag 1) -> WRITE_BACK with addr 0x010, data {A0,0xBEEF,A2,A3}, rw=1, then ALLOCATE with addr 0x050. ram[0x011] now holds 0xBEEF.
- Write miss: write 0x0A3=0x1234 to a cold line -> refill from 0x0A0, merge; read back 0x1234, line dirty.
- Handshake check: assert cs drops to 0 the cycle after every ack; cs is never high in IDLE or COMPARE; exactly one mem_ctrl transaction per phase.
- Reset mid-ALLOCATE: assert rst while cs=1 -> cs=0 and ready=0 immediately. After release, re-read of the same address misses and refills.
